// File: rtl/audio_codec_pkg.sv
// Shared definitions for the codec serial audio link: word width, receiver FSM
// encoding and the BCK/LRCK ratios the codec-side generator also uses.
package audio_codec_pkg;

    localparam int   DATA_WIDTH_DEF  = 16;
    localparam logic LRCK_LEFT_LEVEL = 1'b1;

    // iCLK_18_4 cycles per BCK period and BCK periods per LRCK frame
    localparam int CLK_PER_BCK  = 12;
    localparam int BCK_PER_LRCK = 32;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/audio_adc_rx_if.sv
// Stereo sample hand-off from the ADC receiver to downstream synth/effects logic.
interface audio_adc_rx_if
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    // oVALID rises with a new pair and holds it stable until a cycle with
    // oVALID && iREADY at posedge transfers it; iREADY may toggle freely.
    logic [DATA_WIDTH-1:0] oLEFT;
    logic [DATA_WIDTH-1:0] oRIGHT;
    logic                  oVALID;
    logic                  iREADY;

    modport master (output oLEFT, output oRIGHT, output oVALID, input iREADY);
    modport slave  (input oLEFT, input oRIGHT, input oVALID, output iREADY);

endinterface

// File: rtl/audio_pin_sync.sv
// Multi-flop synchroniser for one asynchronous codec pin, plus one history
// register that yields single-cycle rise/fall pulses in the iCLK_18_4 domain.
module audio_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iCLK_18_4,
    input  logic iRST,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/audio_adc_rx.sv
// Codec ADC serial receiver: oversamples BCK/ADCLRCK/ADCDAT and emits one stereo pair
// per LRCK frame. Define AUDIO_RX_PEAK_EN to enable the oPEAK magnitude tracker.
module audio_adc_rx
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int I2S_DELAY   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_ADCLRCK,
    input  logic                  iAUD_ADCDAT,
    audio_adc_rx_if.master        bus,
    output logic                  oOVERRUN,
    output logic                  oFRAME_ERR,
    output logic [DATA_WIDTH-1:0] oPEAK,
    output rx_state_t             oDBG_STATE
);

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int SKIP_W = (I2S_DELAY > 0) ? $clog2(I2S_DELAY + 1) : 1;

    logic bck_lvl, bck_rise, bck_fall;
    logic lrck_lvl, lrck_rise, lrck_fall;
    logic dat_lvl, dat_rise, dat_fall;

    audio_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
        .iCLK_18_4 (iCLK_18_4), .iRST (iRST), .pin (iAUD_BCK),
        .level (bck_lvl), .rise (bck_rise), .fall (bck_fall)
    );

    audio_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .iCLK_18_4 (iCLK_18_4), .iRST (iRST), .pin (iAUD_ADCLRCK),
        .level (lrck_lvl), .rise (lrck_rise), .fall (lrck_fall)
    );

    audio_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .iCLK_18_4 (iCLK_18_4), .iRST (iRST), .pin (iAUD_ADCDAT),
        .level (dat_lvl), .rise (dat_rise), .fall (dat_fall)
    );

    logic unused_pin_edges;
    assign unused_pin_edges = &{1'b0, bck_lvl, bck_fall, dat_rise, dat_fall};

    rx_state_t             state_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [SKIP_W-1:0]     skip_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  chan_left_q;
    logic                  left_ok_q;
    logic                  pair_pend_q;

    logic                  lrck_edge;
    logic                  lrck_is_left;
    logic                  skip_done;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  accept;

    assign lrck_edge    = lrck_rise | lrck_fall;
    assign lrck_is_left = (lrck_lvl == LRCK_LEFT_LEVEL);
    assign skip_done    = (skip_cnt_q == SKIP_W'(I2S_DELAY));
    assign last_bit     = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign shift_nxt    = {shift_q[DATA_WIDTH-2:0], dat_lvl};
    assign accept       = bus.oVALID && bus.iREADY;
    assign oDBG_STATE   = state_q;

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state_q     <= ST_HUNT;
            bit_cnt_q   <= '0;
            skip_cnt_q  <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            chan_left_q <= 1'b0;
            left_ok_q   <= 1'b0;
            pair_pend_q <= 1'b0;
            oFRAME_ERR  <= 1'b0;
        end else begin
            pair_pend_q <= 1'b0;
            // A channel boundary restarts the word from any state except HUNT,
            // which only leaves on the start of a left word.
            if (lrck_edge && (state_q != ST_HUNT || lrck_is_left)) begin
                state_q     <= ST_SKIP;
                chan_left_q <= lrck_is_left;
                skip_cnt_q  <= '0;
                bit_cnt_q   <= '0;
                if (lrck_is_left || state_q == ST_SHIFT) begin
                    left_ok_q <= 1'b0;
                end
                if (state_q == ST_SHIFT) begin
                    oFRAME_ERR <= 1'b1;
                end
            end else if (bck_rise) begin
                case (state_q)
                    ST_SKIP: begin
                        if (skip_done) begin
                            shift_q   <= shift_nxt;
                            bit_cnt_q <= CNT_W'(1);
                            state_q   <= ST_SHIFT;
                        end else begin
                            skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
                        end
                    end
                    ST_SHIFT: begin
                        shift_q   <= shift_nxt;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            state_q <= ST_DONE;
                            if (chan_left_q) begin
                                hold_q    <= shift_nxt;
                                left_ok_q <= 1'b1;
                            end else begin
                                // a right word without a good left partner is dropped
                                pair_pend_q <= left_ok_q;
                                left_ok_q   <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            bus.oLEFT  <= '0;
            bus.oRIGHT <= '0;
            bus.oVALID <= 1'b0;
            oOVERRUN   <= 1'b0;
        end else if (pair_pend_q) begin
            bus.oLEFT  <= hold_q;
            bus.oRIGHT <= shift_q;
            bus.oVALID <= 1'b1;
            if (bus.oVALID && !bus.iREADY) begin
                oOVERRUN <= 1'b1;
            end
        end else if (accept) begin
            bus.oVALID <= 1'b0;
        end
    end

`ifdef AUDIO_RX_PEAK_EN
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] ONE_W    = DATA_WIDTH'(1);

    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] s);
        if (!s[DATA_WIDTH-1])  return s;
        else if (s == MOST_NEG) return MOST_POS;
        else                   return ~s + ONE_W;
    endfunction

    logic [DATA_WIDTH-1:0] abs_l, abs_r, pair_max, peak_base;

    always_comb begin
        abs_l     = abs_sat(hold_q);
        abs_r     = abs_sat(shift_q);
        pair_max  = (abs_l > abs_r) ? abs_l : abs_r;
        peak_base = accept ? '0 : oPEAK;
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            oPEAK <= '0;
        end else if (pair_pend_q) begin
            oPEAK <= (pair_max > peak_base) ? pair_max : peak_base;
        end else if (accept) begin
            oPEAK <= '0;
        end
    end
`else
    assign oPEAK = '0;
`endif

endmodule
